// File: rtl/ddr_cmd_pkg.sv
// Shared command encoding, state enum and sizing helpers
// for the DDR command scheduler.
package ddr_cmd_pkg;

    localparam int CMD_W    = 19;
    localparam int CMD_ACT  = 0;
    localparam int CMD_PRE  = 1;
    localparam int CMD_PREA = 2;
    localparam int CMD_RD   = 3;
    localparam int CMD_WR   = 4;
    localparam int CMD_REF  = 5;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PRE,
        ST_PRE_WAIT,
        ST_ACT,
        ST_ACT_WAIT,
        ST_RW,
        ST_PREA_ISSUE,
        ST_PREA_WAIT,
        ST_REF_ISSUE,
        ST_REF_WAIT
    } state_e;

    function automatic int cnt_w(input int max_load);
        return (max_load < 2) ? 1 : $clog2(max_load + 1);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/bank_tracker.sv
// Per-bank open flag, open row and tRAS down-counter,
// with lookup, set, clear and clear-all ports.
module bank_tracker
    import ddr_cmd_pkg::*;
#(
    parameter int BANKS     = 16,
    parameter int BANK_W    = 4,
    parameter int ADDRWIDTH = 17,
    parameter int TRAS      = 10
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 halt,
    input  logic [BANK_W-1:0]    lookup_idx,
    output logic                 lookup_open,
    output logic [ADDRWIDTH-1:0] lookup_row,
    output logic                 lookup_tras_zero,
    output logic                 all_tras_zero,
    input  logic                 set_en,
    input  logic [BANK_W-1:0]    set_idx,
    input  logic [ADDRWIDTH-1:0] set_row,
    input  logic                 clr_en,
    input  logic [BANK_W-1:0]    clr_idx,
    input  logic                 clr_all
);

    localparam int TRAS_W = cnt_w(TRAS - 1);
    localparam logic [TRAS_W-1:0] TRAS_LOAD = TRAS_W'(TRAS - 1);

    logic [BANKS-1:0]     open_q, open_d;
    logic [ADDRWIDTH-1:0] row_q  [BANKS];
    logic [ADDRWIDTH-1:0] row_d  [BANKS];
    logic [TRAS_W-1:0]    tras_q [BANKS];
    logic [TRAS_W-1:0]    tras_d [BANKS];

    assign lookup_open      = open_q[lookup_idx];
    assign lookup_row       = row_q[lookup_idx];
    assign lookup_tras_zero = (tras_q[lookup_idx] == '0);

    always_comb begin
        all_tras_zero = 1'b1;
        for (int b = 0; b < BANKS; b++) begin
            if (tras_q[b] != '0) all_tras_zero = 1'b0;
        end
    end

    always_comb begin
        open_d = open_q;
        row_d  = row_q;
        for (int b = 0; b < BANKS; b++) begin
            if (halt || tras_q[b] == '0)
                tras_d[b] = tras_q[b];
            else
                tras_d[b] = tras_q[b] - TRAS_W'(1);
        end
        if (clr_all) open_d = '0;
        if (clr_en) open_d[clr_idx] = 1'b0;
        if (set_en) begin
            open_d[set_idx] = 1'b1;
            row_d[set_idx]  = set_row;
            tras_d[set_idx] = TRAS_LOAD;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            open_q <= '0;
            for (int b = 0; b < BANKS; b++) begin
                row_q[b]  <= '0;
                tras_q[b] <= '0;
            end
        end else begin
            open_q <= open_d;
            for (int b = 0; b < BANKS; b++) begin
                row_q[b]  <= row_d[b];
                tras_q[b] <= tras_d[b];
            end
        end
    end

endmodule

// File: rtl/ddr_cmd_scheduler.sv
// DDR command scheduler: open-page request sequencing with
// ACT/PRE/RD/WR spacing and periodic PREA + REF.
module ddr_cmd_scheduler
    import ddr_cmd_pkg::*;
#(
    parameter int BGWIDTH   = 2,
    parameter int BAWIDTH   = 2,
    parameter int ADDRWIDTH = 17,
    parameter int COLWIDTH  = 10,
    parameter int TRCD      = 4,
    parameter int TRP       = 4,
    parameter int TRAS      = 10,
    parameter int TCCD      = 4,
    parameter int TREFI     = 1560,
    parameter int TRFC      = 88
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 halt,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [BGWIDTH:0]     req_bg,
    input  logic [BAWIDTH:0]     req_ba,
    input  logic [ADDRWIDTH-1:0] req_row,
    input  logic [COLWIDTH-1:0]  req_col,
    output logic                 req_done,
    output logic [CMD_W-1:0]     commands,
    output logic [BGWIDTH:0]     bg,
    output logic [BAWIDTH:0]     ba,
    output logic [ADDRWIDTH-1:0] row,
    output logic [COLWIDTH-1:0]  column
);

    localparam int BANKS  = BGWIDTH**2 * BAWIDTH**2;
    localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;
    localparam int WAIT_W = cnt_w(max3(TRP - 1, TRCD - 1, TRFC - 1));
    localparam int TCCD_W = cnt_w(TCCD - 1);
    localparam int REFI_W = cnt_w(TREFI - 1);

    localparam logic [WAIT_W-1:0] TRP_LOAD  = WAIT_W'(TRP - 1);
    localparam logic [WAIT_W-1:0] TRCD_LOAD = WAIT_W'(TRCD - 1);
    localparam logic [WAIT_W-1:0] TRFC_LOAD = WAIT_W'(TRFC - 1);
    localparam logic [TCCD_W-1:0] TCCD_LOAD = TCCD_W'(TCCD - 1);
    localparam logic [REFI_W-1:0] REFI_LOAD = REFI_W'(TREFI - 1);

    state_e state_q, state_d, es;

    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [TCCD_W-1:0] tccd_q, tccd_d;
    logic [REFI_W-1:0] refi_q, refi_d;
    logic              pend_q, pend_d;
    logic              expire;

    logic                 lat_write_q, lat_write_d;
    logic [BGWIDTH:0]     lat_bg_q, lat_bg_d;
    logic [BAWIDTH:0]     lat_ba_q, lat_ba_d;
    logic [ADDRWIDTH-1:0] lat_row_q, lat_row_d;
    logic [COLWIDTH-1:0]  lat_col_q, lat_col_d;

    logic [CMD_W-1:0]     cmd_q, cmd_d;
    logic                 done_q, done_d;
    logic [BGWIDTH:0]     bg_q, bg_d;
    logic [BAWIDTH:0]     ba_q, ba_d;
    logic [ADDRWIDTH-1:0] row_q, row_d;
    logic [COLWIDTH-1:0]  col_q, col_d;

    logic                 idle, accept;
    logic                 cur_write;
    logic [BGWIDTH:0]     cur_bg;
    logic [BAWIDTH:0]     cur_ba;
    logic [ADDRWIDTH-1:0] cur_row;
    logic [COLWIDTH-1:0]  cur_col;
    logic [BANK_W-1:0]    bank_idx;

    logic                 lk_open, lk_tras_zero, all_tras_zero;
    logic [ADDRWIDTH-1:0] lk_row;
    logic                 set_en, clr_en, clr_all;

    assign idle      = (state_q == ST_IDLE);
    assign req_ready = idle && !pend_q && !halt;
    assign accept    = req_valid && req_ready;

    // Fresh request fields are used in the accept cycle so the
    // first command can issue on the very next cycle.
    assign cur_write = idle ? req_write : lat_write_q;
    assign cur_bg    = idle ? req_bg    : lat_bg_q;
    assign cur_ba    = idle ? req_ba    : lat_ba_q;
    assign cur_row   = idle ? req_row   : lat_row_q;
    assign cur_col   = idle ? req_col   : lat_col_q;
    assign bank_idx  = BANK_W'({cur_bg, cur_ba});

    bank_tracker #(
        .BANKS     (BANKS),
        .BANK_W    (BANK_W),
        .ADDRWIDTH (ADDRWIDTH),
        .TRAS      (TRAS)
    ) u_banks (
        .clk              (clk),
        .reset_n          (reset_n),
        .halt             (halt),
        .lookup_idx       (bank_idx),
        .lookup_open      (lk_open),
        .lookup_row       (lk_row),
        .lookup_tras_zero (lk_tras_zero),
        .all_tras_zero    (all_tras_zero),
        .set_en           (set_en),
        .set_idx          (bank_idx),
        .set_row          (cur_row),
        .clr_en           (clr_en),
        .clr_idx          (bank_idx),
        .clr_all          (clr_all)
    );

    always_comb begin
        state_d = state_q;
        es      = state_q;
        wait_d  = (halt || wait_q == '0) ? wait_q : wait_q - WAIT_W'(1);
        tccd_d  = (halt || tccd_q == '0) ? tccd_q : tccd_q - TCCD_W'(1);
        refi_d  = refi_q;
        expire  = 1'b0;
        if (!halt) begin
            if (refi_q == '0) begin
                refi_d = REFI_LOAD;
                expire = 1'b1;
            end else begin
                refi_d = refi_q - REFI_W'(1);
            end
        end
        pend_d      = pend_q | expire;
        lat_write_d = lat_write_q;
        lat_bg_d    = lat_bg_q;
        lat_ba_d    = lat_ba_q;
        lat_row_d   = lat_row_q;
        lat_col_d   = lat_col_q;
        cmd_d       = '0;
        done_d      = 1'b0;
        bg_d        = bg_q;
        ba_d        = ba_q;
        row_d       = row_q;
        col_d       = col_q;
        set_en      = 1'b0;
        clr_en      = 1'b0;
        clr_all     = 1'b0;

        if (!halt) begin
            // Resolve expired waits into the state that acts now.
            unique case (state_q)
                ST_IDLE: begin
                    if (pend_q) begin
                        es = ST_PREA_ISSUE;
                    end else if (accept) begin
                        lat_write_d = req_write;
                        lat_bg_d    = req_bg;
                        lat_ba_d    = req_ba;
                        lat_row_d   = req_row;
                        lat_col_d   = req_col;
                        if (lk_open && lk_row == req_row)
                            es = ST_RW;
                        else if (lk_open)
                            es = ST_PRE;
                        else
                            es = ST_ACT;
                    end
                end
                ST_PRE_WAIT:  if (wait_q == '0) es = ST_ACT;
                ST_ACT_WAIT:  if (wait_q == '0) es = ST_RW;
                ST_PREA_WAIT: if (wait_q == '0) es = ST_REF_ISSUE;
                ST_REF_WAIT:  if (wait_q == '0) es = ST_IDLE;
                default: ;
            endcase

            unique case (es)
                ST_PRE: begin
                    state_d = ST_PRE;
                    if (lk_tras_zero) begin
                        cmd_d[CMD_PRE] = 1'b1;
                        clr_en  = 1'b1;
                        wait_d  = TRP_LOAD;
                        state_d = ST_PRE_WAIT;
                    end
                end
                ST_ACT: begin
                    cmd_d[CMD_ACT] = 1'b1;
                    set_en  = 1'b1;
                    wait_d  = TRCD_LOAD;
                    state_d = ST_ACT_WAIT;
                end
                ST_RW: begin
                    state_d = ST_RW;
                    if (tccd_q == '0) begin
                        cmd_d[CMD_WR] = cur_write;
                        cmd_d[CMD_RD] = !cur_write;
                        done_d  = 1'b1;
                        tccd_d  = TCCD_LOAD;
                        state_d = ST_IDLE;
                    end
                end
                ST_PREA_ISSUE: begin
                    state_d = ST_PREA_ISSUE;
                    if (all_tras_zero) begin
                        cmd_d[CMD_PREA] = 1'b1;
                        clr_all = 1'b1;
                        wait_d  = TRP_LOAD;
                        state_d = ST_PREA_WAIT;
                    end
                end
                ST_REF_ISSUE: begin
                    cmd_d[CMD_REF] = 1'b1;
                    pend_d  = 1'b0;
                    wait_d  = TRFC_LOAD;
                    state_d = ST_REF_WAIT;
                end
                default: state_d = es;
            endcase

            if (cmd_d[CMD_ACT] | cmd_d[CMD_PRE] |
                cmd_d[CMD_RD]  | cmd_d[CMD_WR]) begin
                bg_d  = cur_bg;
                ba_d  = cur_ba;
                row_d = cur_row;
                col_d = cur_col;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            wait_q      <= '0;
            tccd_q      <= '0;
            refi_q      <= REFI_LOAD;
            pend_q      <= 1'b0;
            lat_write_q <= 1'b0;
            lat_bg_q    <= '0;
            lat_ba_q    <= '0;
            lat_row_q   <= '0;
            lat_col_q   <= '0;
            cmd_q       <= '0;
            done_q      <= 1'b0;
            bg_q        <= '0;
            ba_q        <= '0;
            row_q       <= '0;
            col_q       <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            tccd_q      <= tccd_d;
            refi_q      <= refi_d;
            pend_q      <= pend_d;
            lat_write_q <= lat_write_d;
            lat_bg_q    <= lat_bg_d;
            lat_ba_q    <= lat_ba_d;
            lat_row_q   <= lat_row_d;
            lat_col_q   <= lat_col_d;
            cmd_q       <= cmd_d;
            done_q      <= done_d;
            bg_q        <= bg_d;
            ba_q        <= ba_d;
            row_q       <= row_d;
            col_q       <= col_d;
        end
    end

    assign commands = cmd_q;
    assign req_done = done_q;
    assign bg       = bg_q;
    assign ba       = ba_q;
    assign row      = row_q;
    assign column   = col_q;

endmodule

// File: tb/tb_ddr_cmd_scheduler.sv
// Scoreboard bench for ddr_cmd_scheduler: directed requests
// push expected commands; a negedge monitor pops and compares.
module tb_ddr_cmd_scheduler;

    localparam logic [18:0] C_ACT  = 19'h01;
    localparam logic [18:0] C_PRE  = 19'h02;
    localparam logic [18:0] C_PREA = 19'h04;
    localparam logic [18:0] C_RD   = 19'h08;
    localparam logic [18:0] C_WR   = 19'h10;
    localparam logic [18:0] C_REF  = 19'h20;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        halt;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_bg;
    logic [2:0]  req_ba;
    logic [16:0] req_row;
    logic [9:0]  req_col;
    logic        req_done;
    logic [18:0] commands;
    logic [2:0]  bg;
    logic [2:0]  ba;
    logic [16:0] row;
    logic [9:0]  column;

    typedef struct {
        logic [18:0] cmd;
        logic [2:0]  bg;
        logic [2:0]  ba;
        logic [16:0] row;
        logic [9:0]  col;
        bit          chk;
        int          at;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc;

    ddr_cmd_scheduler dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .halt      (halt),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_bg    (req_bg),
        .req_ba    (req_ba),
        .req_row   (req_row),
        .req_col   (req_col),
        .req_done  (req_done),
        .commands  (commands),
        .bg        (bg),
        .ba        (ba),
        .row       (row),
        .column    (column)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic check(input string name,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, got, exp, cyc);
        end
    endtask

    task automatic push(input logic [18:0] c,
                        input logic [2:0] pbg,
                        input logic [2:0] pba,
                        input logic [16:0] prow,
                        input logic [9:0] pcol,
                        input bit pchk,
                        input int pat);
        q.push_back('{c, pbg, pba, prow, pcol, pchk, pat});
    endtask

    // Returns the cycle number in which the request was accepted.
    task automatic send(input logic w,
                        input logic [2:0] sbg,
                        input logic [2:0] sba,
                        input logic [16:0] srow,
                        input logic [9:0] scol,
                        output int t);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (n >= 300) check("send_timeout", 64'd0, 64'd1);
        req_valid = 1'b1;
        req_write = w;
        req_bg    = sbg;
        req_ba    = sba;
        req_row   = srow;
        req_col   = scol;
        t         = cyc;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (reset_n && (commands != '0 || req_done)) begin
            if (q.size() == 0) begin
                check("unexpected_cmd", {commands, req_done}, 64'd0);
            end else begin
                me = q.pop_front();
                check("cmd", commands, me.cmd);
                check("cmd_cycle", cyc, me.at);
                check("req_done", req_done, me.cmd[3] | me.cmd[4]);
                if (me.chk)
                    check("addr", {bg, ba, row, column},
                          {me.bg, me.ba, me.row, me.col});
            end
        end
    end

    initial begin
        int t0, t, th, tr, ta, n;
        reset_n   = 1'b0;
        halt      = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_bg    = '0;
        req_ba    = '0;
        req_row   = '0;
        req_col   = '0;
        repeat (3) @(negedge clk);
        check("rst_cmd", commands, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_ready", req_ready, 64'd1);
        check("rst_done", req_done, 64'd0);
        check("rst_addr", {bg, ba, row, column}, 64'd0);

        // closed bank: ACT then RD after tRCD
        send(1'b0, 3'd0, 3'd0, 17'd5, 10'd8, t0);
        push(C_ACT, 3'd0, 3'd0, 17'd5, 10'd8, 1'b1, t0 + 1);
        push(C_RD,  3'd0, 3'd0, 17'd5, 10'd8, 1'b1, t0 + 5);
        @(negedge clk);
        check("busy_ready", req_ready, 64'd0);

        // row hit: RD only, tCCD after previous RD
        send(1'b0, 3'd0, 3'd0, 17'd5, 10'd9, t);
        push(C_RD,  3'd0, 3'd0, 17'd5, 10'd9, 1'b1, t0 + 9);

        // row conflict: PRE waits for tRAS
        send(1'b0, 3'd0, 3'd0, 17'd9, 10'h20, t);
        push(C_PRE, 3'd0, 3'd0, 17'd9, 10'h20, 1'b1, t0 + 11);
        push(C_ACT, 3'd0, 3'd0, 17'd9, 10'h20, 1'b1, t0 + 15);
        push(C_RD,  3'd0, 3'd0, 17'd9, 10'h20, 1'b1, t0 + 19);

        // write to bank 10, then an aliasing read (bg bit 1 dropped)
        send(1'b1, 3'd1, 3'd2, 17'd3, 10'h3ff, t);
        push(C_ACT, 3'd1, 3'd2, 17'd3, 10'h3ff, 1'b1, t0 + 20);
        push(C_WR,  3'd1, 3'd2, 17'd3, 10'h3ff, 1'b1, t0 + 24);
        send(1'b0, 3'd3, 3'd2, 17'd3, 10'h011, t);
        push(C_RD,  3'd3, 3'd2, 17'd3, 10'h011, 1'b1, t0 + 28);

        // refresh timer expiry from reset release
        push(C_PREA, 3'd0, 3'd0, 17'd0, 10'd0, 1'b0, 1561);
        push(C_REF,  3'd0, 3'd0, 17'd0, 10'd0, 1'b0, 1565);
        while (cyc < 1565) @(negedge clk);
        n = 0;
        while (!req_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("ref_busy_cycles", n, 64'd88);

        // halt for 20 cycles inside ACT_WAIT
        send(1'b0, 3'd0, 3'd5, 17'd7, 10'd2, th);
        push(C_ACT, 3'd0, 3'd5, 17'd7, 10'd2, 1'b1, th + 1);
        push(C_RD,  3'd0, 3'd5, 17'd7, 10'd2, 1'b1, th + 25);
        @(negedge clk);
        @(negedge clk);
        halt = 1'b1;
        #1 check("halt_ready", req_ready, 64'd0);
        repeat (20) @(negedge clk);
        halt = 1'b0;
        repeat (15) @(negedge clk);

        // reset in PRE_WAIT aborts the sequence
        send(1'b0, 3'd0, 3'd5, 17'd11, 10'd4, tr);
        push(C_PRE, 3'd0, 3'd5, 17'd11, 10'd4, 1'b1, tr + 1);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("abort_cmd", commands, 64'd0);
        check("abort_done", req_done, 64'd0);
        check("abort_addr", {bg, ba, row, column}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        send(1'b0, 3'd0, 3'd5, 17'd11, 10'd4, ta);
        push(C_ACT, 3'd0, 3'd5, 17'd11, 10'd4, 1'b1, ta + 1);
        push(C_RD,  3'd0, 3'd5, 17'd11, 10'd4, 1'b1, ta + 5);

        n = 0;
        while (q.size() != 0 && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("queue_drained", q.size(), 64'd0);
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
